// File: rtl/counter_sweep_ctrl_if.sv
// Control/status bus between the sweep controller and the up/down bounded counter.
// The controller drives the master side and the counter sits on the slave side.
interface counter_sweep_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             cnt_en;
  logic             cnt_set;
  logic [3:0]       cnt_din;
  logic [3:0]       cnt_step;
  logic             cnt_up_down;
  logic [WIDTH-1:0] cnt_count;
  logic             cnt_finish;

  modport master (
    output cnt_en,
    output cnt_set,
    output cnt_din,
    output cnt_step,
    output cnt_up_down,
    input  cnt_count,
    input  cnt_finish
  );

  modport slave (
    input  cnt_en,
    input  cnt_set,
    input  cnt_din,
    input  cnt_step,
    input  cnt_up_down,
    output cnt_count,
    output cnt_finish
  );
endinterface

// File: rtl/counter_sweep_ctrl.sv
// Sweep controller: loads the counter, then sweeps it MIN<->MAX a programmed
// number of times, with a start/busy/done handshake and a stall watchdog.
module counter_sweep_ctrl #(
  parameter int WIDTH    = 8,
  parameter int MAX      = 100,
  parameter int MIN      = 10,
  parameter int SWEEPS_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [3:0]          cfg_din,
  input  logic [3:0]          cfg_step,
  input  logic [SWEEPS_W-1:0] cfg_sweeps,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [SWEEPS_W-1:0] sweep_cnt,
  counter_sweep_ctrl_if.master cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_TURN = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN);
  localparam logic [WIDTH:0]   WD_LAST = {1'b0, {WIDTH{1'b1}}};

  logic [2:0]          state;
  logic [3:0]          din_q;
  logic [3:0]          step_q;
  logic [SWEEPS_W-1:0] sweeps_q;
  logic [SWEEPS_W-1:0] sweep_q;
  logic [SWEEPS_W-1:0] sweep_nxt;
  logic                dir_q;
  logic                err_q;
  logic [WIDTH:0]      wd_q;
  logic                at_end;
  logic                wd_hit;
  logic                unused_finish;

  // Endpoint by compare: a large step may jump past MAX/MIN
  assign at_end = dir_q ? (cnt.cnt_count >= MAX_V)
                        : (cnt.cnt_count <= MIN_V);
  assign wd_hit    = (wd_q == WD_LAST);
  assign sweep_nxt = sweep_q + 1'b1;

  assign unused_finish = cnt.cnt_finish;

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_FIN);
  assign err       = err_q;
  assign sweep_cnt = sweep_q;

  assign cnt.cnt_set     = (state == S_LOAD);
  assign cnt.cnt_din     = din_q;
  assign cnt.cnt_step    = step_q;
  assign cnt.cnt_up_down = dir_q;

  always_comb begin
    cnt.cnt_en = 1'b0;
    unique case (1'b1)
      (state == S_LOAD): cnt.cnt_en = 1'b1;
      (state == S_RUN):  cnt.cnt_en = ~at_end & ~wd_hit;
      default:           cnt.cnt_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      din_q    <= '0;
      step_q   <= '0;
      sweeps_q <= '0;
      sweep_q  <= '0;
      dir_q    <= 1'b1;
      err_q    <= 1'b0;
      wd_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            din_q    <= cfg_din;
            step_q   <= cfg_step;
            sweeps_q <= cfg_sweeps;
            sweep_q  <= '0;
            err_q    <= 1'b0;
            if (cfg_step == 4'd0) begin
              err_q <= 1'b1;
            end else if (cfg_sweeps == '0) begin
              state <= S_FIN;
            end else begin
              state <= S_LOAD;
              dir_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          state <= S_RUN;
          wd_q  <= '0;
        end
        S_RUN: begin
          if (at_end) begin
            state <= S_TURN;
          end else if (wd_hit) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_TURN: begin
          sweep_q <= sweep_nxt;
          dir_q   <= ~dir_q;
          if (sweep_nxt == sweeps_q) begin
            state <= S_FIN;
          end else begin
            state <= S_RUN;
            wd_q  <= '0;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Scoreboarded bench for the sweep controller with a behavioural counter
// model (optionally stuck) on the slave side of the counter bus.
module tb_counter_sweep_ctrl;

  localparam int WIDTH = 8;
  localparam int SW    = 8;

  typedef struct {
    bit is_err;
    int sweeps;
    bit ud;
    int count;
    int en_n;
    int set_n;
    int busy_n;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    cfg_din = '0;
  logic [3:0]    cfg_step = '0;
  logic [SW-1:0] cfg_sweeps = '0;
  logic          busy, done, err;
  logic [SW-1:0] sweep_cnt;
  logic          stuck = 1'b0;

  int total = 0;
  int bad   = 0;
  exp_t q[$];

  counter_sweep_ctrl_if #(.WIDTH(WIDTH)) cif ();

  counter_sweep_ctrl #(
    .WIDTH(WIDTH), .MAX(100), .MIN(10), .SWEEPS_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_din(cfg_din), .cfg_step(cfg_step),
    .cfg_sweeps(cfg_sweeps),
    .busy(busy), .done(done), .err(err),
    .sweep_cnt(sweep_cnt), .cnt(cif.master)
  );

  always #5 clk = ~clk;

  // Attached counter: no reset, no clamping at the endpoints
  logic [WIDTH-1:0] count = '0;
  always @(posedge clk) begin
    if (stuck) count <= 8'd20;
    else if (cif.cnt_en) begin
      if (cif.cnt_set) count <= {4'd0, cif.cnt_din};
      else if (cif.cnt_up_down) count <= count + {4'd0, cif.cnt_step};
      else count <= count - {4'd0, cif.cnt_step};
    end
  end
  assign cif.cnt_count  = count;
  assign cif.cnt_finish = (count == 8'd10) || (count == 8'd100);

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: accumulate activity, pop on done or err rising
  int  en_n = 0, set_n = 0, busy_n = 0;
  bit  err_d = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      en_n = 0; set_n = 0; busy_n = 0; err_d = 1'b0;
    end else begin
      if (cif.cnt_en && !cif.cnt_set) en_n++;
      if (cif.cnt_set) set_n++;
      if (busy) busy_n++;
      if (done || (err && !err_d)) begin
        if (q.size() == 0) begin
          chk("unexpected_event", 1, 0);
        end else begin
          e = q.pop_front();
          chk("event_kind", int'(err), int'(e.is_err));
          chk("done_vs_err", int'(done), int'(!e.is_err));
          chk("sweep_cnt", int'(sweep_cnt), e.sweeps);
          chk("up_down", int'(cif.cnt_up_down), int'(e.ud));
          chk("count", int'(count), e.count);
          if (e.en_n >= 0) chk("en_cycles", en_n, e.en_n);
          if (e.set_n >= 0) chk("set_cycles", set_n, e.set_n);
          if (e.busy_n >= 0) chk("busy_cycles", busy_n, e.busy_n);
        end
        en_n = 0; set_n = 0; busy_n = 0;
      end
      err_d = err;
    end
  end

  task automatic issue(input int d, input int s, input int n, input exp_t e);
    q.push_back(e);
    cfg_din = 4'(d); cfg_step = 4'(s); cfg_sweeps = SW'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string name, input int lim);
    int c = 0;
    while (q.size() != 0 && c < lim) begin
      @(negedge clk);
      c++;
    end
    if (q.size() != 0) begin
      chk({name, "_timeout"}, q.size(), 0);
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  exp_t e;
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_sweep", int'(sweep_cnt), 0);
    chk("rst_set", int'(cif.cnt_set), 0);
    chk("rst_en", int'(cif.cnt_en), 0);
    chk("rst_din", int'(cif.cnt_din), 0);
    chk("rst_step", int'(cif.cnt_step), 0);
    chk("rst_ud", int'(cif.cnt_up_down), 1);
    rst = 1'b1;
    @(negedge clk);

    e = '{0, 2, 1, 10, 180, 1, -1};
    issue(10, 1, 2, e);
    drain("sweep2_step1", 400);

    e = '{0, 1, 0, 101, 13, 1, -1};
    issue(10, 7, 1, e);
    drain("overshoot", 100);

    e = '{1, 0, 0, 101, 0, 0, 0};
    issue(4, 0, 3, e);
    drain("step0", 20);

    e = '{0, 0, 0, 101, 0, 0, 1};
    issue(3, 2, 0, e);
    drain("sweeps0", 20);

    // Re-pulse start while busy: exactly one completion
    e = '{0, 1, 0, 100, 90, 1, -1};
    issue(10, 1, 1, e);
    for (int i = 0; i < 200 && busy; i++) begin
      start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    drain("restart_ignored", 20);
    chk("no_extra_busy", int'(busy), 0);

    // Reset in the middle of a sweep
    cfg_din = 4'd10; cfg_step = 4'd1; cfg_sweeps = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && count != 8'd50; i++) @(negedge clk);
    chk("mid_count_reached", int'(count), 50);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_en", int'(cif.cnt_en), 0);
    chk("mid_rst_ud", int'(cif.cnt_up_down), 1);
    chk("mid_rst_sweep", int'(sweep_cnt), 0);
    @(posedge clk);
    #1;
    chk("mid_rst_frozen", int'(count), 50);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    e = '{0, 3, 0, 100, 53, 1, -1};
    issue(15, 5, 3, e);
    drain("exact_endpoints", 200);

    stuck = 1'b1;
    @(negedge clk);
    e = '{1, 0, 1, 20, -1, -1, -1};
    issue(5, 1, 1, e);
    drain("watchdog", 400);
    stuck = 1'b0;

    e = '{0, 1, 0, 102, 30, 1, -1};
    issue(12, 3, 1, e);
    drain("err_cleared", 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
